// File: rtl/usb_in_ep_mux_pkg.sv
// Shared types and helpers for the USB IN endpoint client multiplexer.
package usb_in_mux_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    OWN      = 2'd2,
    WAIT_ACK = 2'd3
  } in_mux_state_t;

  // Index width for n items; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/usb_in_ep_mux_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module usb_rr_picker
  import usb_in_mux_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned IDX_W       = clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_rr_ptr,
  output logic [IDX_W-1:0]       o_winner,
  output logic                   o_any
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    int unsigned idx;
    o_winner = '0;
    o_any    = 1'b0;
    idx      = 0;
    for (int off = int'(NUM_CLIENTS) - 1; off >= 0; off--) begin
      idx = (int'(i_rr_ptr) + off) % int'(NUM_CLIENTS);
      if (i_req[IDX_W'(idx)]) begin
        o_winner = IDX_W'(idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_in_ep_mux.sv
// Shares one usb_fs_pe IN endpoint slot among NUM_CLIENTS clients, one packet per grant.
// Optional idle-load watchdog enabled by defining USB_IN_MUX_TIMEOUT_EN.
module usb_in_ep_mux
  import usb_in_mux_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd48000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        client_req,
  output logic [NUM_CLIENTS-1:0]        client_grant,
  output logic [NUM_CLIENTS-1:0]        client_data_free,
  input  logic [NUM_CLIENTS-1:0]        client_data_put,
  input  logic [BYTE_W*NUM_CLIENTS-1:0] client_data,
  input  logic [NUM_CLIENTS-1:0]        client_data_done,
  input  logic [NUM_CLIENTS-1:0]        client_stall,
  output logic [NUM_CLIENTS-1:0]        client_acked,
  output logic                          ep_req,
  input  logic                          ep_grant,
  input  logic                          ep_data_free,
  output logic                          ep_data_put,
  output logic [BYTE_W-1:0]             ep_data,
  output logic                          ep_data_done,
  output logic                          ep_stall,
  input  logic                          ep_acked,
  output logic                          timeout_flag
);

  localparam int unsigned IDX_W = clog2(NUM_CLIENTS);

  in_mux_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_owner, w_owner_nxt;
  logic [IDX_W-1:0]       r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0]       w_winner, w_owner_inc;
  logic                   w_any;
  logic                   w_timeout;
  logic [NUM_CLIENTS-1:0] w_owner_oh;
  logic [BYTE_W-1:0]      w_lanes [NUM_CLIENTS];
  logic [BYTE_W-1:0]      w_lane;

  usb_rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .i_req    (client_req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  for (genvar g = 0; g < int'(NUM_CLIENTS); g++) begin : g_lane
    assign w_lanes[g] = client_data[BYTE_W*g +: BYTE_W];
  end

  assign w_lane      = w_lanes[r_owner];
  assign w_owner_oh  = NUM_CLIENTS'(1) << r_owner;
  assign w_owner_inc = (r_owner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : r_owner + IDX_W'(1);

`ifdef USB_IN_MUX_TIMEOUT_EN
  logic [15:0] r_cnt;

  // Counts owned cycles without a byte; cleared by a put or by leaving OWN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state != OWN || client_data_put[r_owner]) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_timeout    = (r_state == OWN) && ep_grant && !client_data_put[r_owner] &&
                        (r_cnt == TIMEOUT_CYCLES - 16'd1);
  assign timeout_flag = w_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign timeout_flag     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Next-state and output decode; a revoked grant drops to IDLE without advancing the pointer.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_rr_nxt         = r_rr_ptr;
    client_grant     = '0;
    client_data_free = '0;
    client_acked     = '0;
    ep_req           = 1'b0;
    ep_data_put      = 1'b0;
    ep_data          = '0;
    ep_data_done     = 1'b0;
    ep_stall         = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_nxt = w_winner;
          w_state_nxt = REQ;
        end
      end

      REQ: begin
        ep_req = 1'b1;
        if (!client_req[r_owner]) begin
          w_state_nxt = IDLE;
        end else if (ep_grant) begin
          w_state_nxt = OWN;
        end
      end

      OWN: begin
        ep_req           = 1'b1;
        client_grant     = w_owner_oh;
        client_data_free = ep_data_free ? w_owner_oh : '0;
        ep_data_put      = client_data_put[r_owner];
        ep_data          = w_lane;
        ep_stall         = client_stall[r_owner];
        ep_data_done     = client_data_done[r_owner] | w_timeout;
        if (!ep_grant) begin
          w_state_nxt = IDLE;
        end else if (client_data_done[r_owner] || w_timeout) begin
          w_state_nxt = WAIT_ACK;
        end else if (!client_req[r_owner]) begin
          w_rr_nxt    = w_owner_inc;
          w_state_nxt = IDLE;
        end
      end

      WAIT_ACK: begin
        ep_req       = 1'b1;
        client_grant = w_owner_oh;
        client_acked = ep_acked ? w_owner_oh : '0;
        if (ep_acked) begin
          w_rr_nxt    = w_owner_inc;
          w_state_nxt = IDLE;
        end else if (!ep_grant) begin
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/usb_in_ep_mux.md
# usb_in_ep_mux

Shares one IN endpoint of the full-speed protocol engine (`usb_fs_pe`) between up to `NUM_CLIENTS` client modules, such as an LED-status source, a debug stream and a counter dump. It sits between the clients and one slot of the engine's `in_ep_*` bus vectors. It arbitrates round-robin, holds ownership for one complete packet (load, `data_done`, `acked`), and muxes the data, free, stall and ack signals.

## Interface
Parameters:
- `NUM_CLIENTS`, default 4: number of clients, range 2–8.
- `TIMEOUT_CYCLES`, default 16'd48000: idle-load watchdog limit. Used only when `USB_IN_MUX_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  48 MHz clock.
- `reset`  in  1  asynchronous, active-high reset.
- `client_req`  in  NUM_CLIENTS  per-client request to send a packet.
- `client_grant`  out  NUM_CLIENTS  one-hot ownership.
- `client_data_free`  out  NUM_CLIENTS  `ep_data_free`, routed to the owner only.
- `client_data_put`  in  NUM_CLIENTS  byte strobe.
- `client_data`  in  8*NUM_CLIENTS  byte lanes; client i uses bits [8i+7:8i].
- `client_data_done`  in  NUM_CLIENTS  packet complete.
- `client_stall`  in  NUM_CLIENTS  stall request.
- `client_acked`  out  NUM_CLIENTS  ack pulse, routed to the owner only.
- `ep_req`  out  1; `ep_grant`  in  1; `ep_data_free`  in  1; `ep_data_put`  out  1; `ep_data`  out  8; `ep_data_done`  out  1; `ep_stall`  out  1; `ep_acked`  in  1. These connect to one engine IN slot.
- `timeout_flag`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
State machine: IDLE → REQ → OWN → WAIT_ACK → IDLE.

Registered state:
- `state`
- `owner` (clog2 width)
- `rr_ptr` (clog2 width)
- watchdog counter

All outputs are combinational decodes of the registered state and live inputs.

- **IDLE:**
  - All outputs are 0.
  - If any `client_req` bit is set, the winner is the first set bit at or after `rr_ptr`, wrapping modulo NUM_CLIENTS.
  - Latch the winner into `owner` and go to REQ.
- **REQ:**
  - `ep_req`=1.
  - If `client_req[owner]` drops, go to IDLE; `rr_ptr` is unchanged.
  - Else, if `ep_grant`=1, go to OWN.
- **OWN:**
  - `ep_req`=1 and `client_grant[owner]`=1.
  - `client_data_free[owner]`=`ep_data_free`.
  - `ep_data_put`=`client_data_put[owner]` and `ep_data`=owner's lane.
  - `ep_stall`=`client_stall[owner]`.
  - `ep_data_done`=`client_data_done[owner]`; on that cycle go to WAIT_ACK.
  - If `client_req[owner]` drops without done: go to IDLE and set `rr_ptr`=owner+1.
  - Done and req-drop in the same cycle: done wins.
- **WAIT_ACK:**
  - `ep_req`=1 and `client_grant[owner]`=1; the data path is muted, so `ep_data_put`=0.
  - On `ep_acked`: `client_acked[owner]`=`ep_acked` (same cycle), then set `rr_ptr`=owner+1 (wrap) and go to IDLE.
- **Grant revoked:** `ep_grant`=0 while in OWN or WAIT_ACK means the engine revoked the grant. Go to IDLE with no ack and no `rr_ptr` advance, so the same client is retried first.
- **Isolation:** non-owner clients see `client_grant`, `client_data_free` and `client_acked` all 0. Their put, done and stall inputs are ignored.
- **Reset:** asynchronous. From any state it forces IDLE with `owner`=0, `rr_ptr`=0 and counter=0. All outputs are 0 in the same cycle. An in-flight packet is abandoned silently.

## Timing
- `client_req` rising at cycle n (in IDLE) → `ep_req`=1 at n+1.
- `ep_grant` high at cycle k (in REQ) → `client_grant` at k+1.
- Data, put, done, stall and ack paths have zero-cycle latency: pure muxes.
- After `ep_acked` at cycle m, the next arbitration decision happens at m+1 and the next `ep_req` at m+2.
- Worst-case wait for any continuously requesting client is NUM_CLIENTS−1 packets.

## Configuration
- `USB_IN_MUX_TIMEOUT_EN` defined:
  - In OWN, the counter increments each cycle without `client_data_put[owner]` and clears on a put.
  - When it reaches `TIMEOUT_CYCLES`: drive `ep_data_done`=1 for one cycle, pulse `timeout_flag`, and go to WAIT_ACK.
  - The engine then sends a short or zero-length packet.
- Undefined: no counter is present, `timeout_flag` is tied 0, and a client may hold OWN indefinitely.

## Structure
- Package `usb_in_mux_pkg` holds:
  - the state enum `in_mux_state_t` (IDLE, REQ, OWN, WAIT_ACK);
  - the byte-width constant (8);
  - the `clog2` helper for the index widths.
- Sub-module `usb_rr_picker`: combinational round-robin winner select.
  - Inputs: req vector, `rr_ptr`.
  - Outputs: winner index, `any`.
  - Instantiated once.

## Test plan
- **Single client:** client 2 reqs, `ep_grant` at cycle 3, puts 0xA5 then 0x5A, done, `ep_acked` 4 cycles later.
  - Expect `ep_data` sequence A5, 5A; one `ep_data_done` pulse; `client_acked`=4'b0100 pulse; `rr_ptr`=3.
- **Fairness:** clients 0, 1 and 3 request continuously.
  - Grant order 0, 1, 3, 0, 1, 3 over 6 packets.
  - No `client_grant` pulse on client 2.
- **Abort:** client 1 drops req in OWN after 2 puts.
  - Expect IDLE next cycle, no ack, `rr_ptr`=2.
- **Simultaneous done and req-drop:** go to WAIT_ACK; `client_acked` is delivered.
- **Grant revoke and reset:**
  - `ep_grant` falls during WAIT_ACK → same client regranted next.
  - `reset` asserted mid-OWN → all outputs 0 immediately.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=16):** owner idles 16 cycles.
  - Expect `ep_data_done` and `timeout_flag` pulses on cycle 16.
  - Without the macro, `timeout_flag` stays 0.
